// File: rtl/csr_pkg.sv
// CSR address map, funct3 encodings and small helpers shared by the CSR execute stage.
package csr_pkg;

    // Read/write machine-mode CSR owned by this stage
    localparam logic [11:0] CSR_TOHOST   = 12'h51E;

    // Read-only user counters (low/high halves)
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    // funct3 (Inst[14:12]) encodings of the Zicsr instructions
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // funct3[1:0] selects the operation; funct3[2] selects the immediate source
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // Addresses with [11:10] == 2'b11 are architecturally read-only
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running wide counter with synchronous active-low clear and increment enable.
// The full-width add makes a low-half wrap carry into the high half on the same edge.
module csr_counter64 #(
    parameter int          W    = 64,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [31:0]   lo,
    output logic [W-33:0] hi
);

    logic [W-1:0] cnt;

    // Clear to INIT on reset, otherwise count up (wrapping) when enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= INIT;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign lo = cnt[31:0];
    assign hi = cnt[W-1:32];

endmodule

// File: rtl/csr_unit.sv
// CSR execute stage: performs CSRRW/S/C[I], owns tohost and the cycle/instret counters.
// Handshake: an op is accepted on an edge when valid & csr_en & ~stall and funct3 names a
// CSR op; there is no other backpressure. Results (rd_data, csr_illegal, tohost_wr) appear
// registered one cycle after acceptance. stall freezes rd_data/csr_illegal and blocks writes.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] TOHOST_RST = 32'h0,
    parameter int          CNT_W      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        valid,
    input  logic        csr_en,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_idx,
    input  logic [31:0] rs1_data,
    input  logic [31:0] imm,
    input  logic        retire,
    output logic [31:0] rd_data,
    output logic        csr_illegal,
    output logic [31:0] tohost,
    output logic        tohost_wr
);

    logic [31:0]       cyc_lo;
    logic [CNT_W-33:0] cyc_hi;
    logic [31:0]       ir_lo;
    logic [CNT_W-33:0] ir_hi;

    csr_op_e     op;
    logic        issue;
    logic [31:0] src;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        mapped;
    logic        wen;
    logic        illegal;
    logic        tohost_we;

    csr_counter64 #(.W(CNT_W)) u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .lo    (cyc_lo),
        .hi    (cyc_hi)
    );

    csr_counter64 #(.W(CNT_W)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .lo    (ir_lo),
        .hi    (ir_hi)
    );

    // Decode, address map read (pre-write value) and new-value computation
    always_comb begin
        op      = csr_op_e'(funct3[1:0]);
        issue   = valid & csr_en & ~stall & (op != OP_NONE);
        src     = funct3[2] ? imm : rs1_data;

        mapped  = 1'b1;
        old_val = '0;
        case (csr_addr)
            CSR_TOHOST:              old_val = tohost;
            CSR_CYCLE,   CSR_TIME:   old_val = cyc_lo;
            CSR_CYCLEH,  CSR_TIMEH:  old_val = 32'(cyc_hi);
            CSR_INSTRET:             old_val = ir_lo;
            CSR_INSTRETH:            old_val = 32'(ir_hi);
            default:                 mapped  = 1'b0;
        endcase

        // Set/clear with a zero source (x0 or zimm==0) is a pure read
        wen     = 1'b0;
        new_val = old_val;
        case (op)
            OP_RW: begin
                wen     = 1'b1;
                new_val = src;
            end
            OP_RS: begin
                wen     = funct3[2] ? (imm[4:0] != 5'd0) : (rs1_idx != 5'd0);
                new_val = old_val | src;
            end
            OP_RC: begin
                wen     = funct3[2] ? (imm[4:0] != 5'd0) : (rs1_idx != 5'd0);
                new_val = old_val & ~src;
            end
            default: begin
                wen     = 1'b0;
                new_val = old_val;
            end
        endcase

        illegal   = ~mapped | (csr_is_ro(csr_addr) & wen);
        tohost_we = issue & ~illegal & wen & (csr_addr == CSR_TOHOST);
    end

    // Registered results and tohost state; stall holds the result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data     <= '0;
            csr_illegal <= 1'b0;
            tohost      <= TOHOST_RST;
            tohost_wr   <= 1'b0;
        end else if (issue) begin
            rd_data     <= old_val;
            csr_illegal <= illegal;
            tohost_wr   <= tohost_we;
            if (tohost_we) begin
                tohost <= new_val;
            end
        end else begin
            tohost_wr <= 1'b0;
            if (!stall) begin
                rd_data     <= '0;
                csr_illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed vector table, hand sequences and random
// stimulus compared against a behavioural model of the CSR rules.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        valid;
    logic        csr_en;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic [31:0] imm;
    logic        retire;
    logic [31:0] rd_data;
    logic        csr_illegal;
    logic [31:0] tohost;
    logic        tohost_wr;

    // Standalone counters preloaded near their wrap points
    logic        c_clr_n;
    logic        c_inc;
    logic [31:0] ca_lo, ca_hi, cb_lo, cb_hi;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_cycle, m_instret;
    logic [31:0] m_tohost, m_rd;
    logic        m_ill, m_wr;

    always #5 clk = ~clk;

    csr_unit #(.TOHOST_RST(32'h0), .CNT_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .valid       (valid),
        .csr_en      (csr_en),
        .funct3      (funct3),
        .csr_addr    (csr_addr),
        .rs1_idx     (rs1_idx),
        .rs1_data    (rs1_data),
        .imm         (imm),
        .retire      (retire),
        .rd_data     (rd_data),
        .csr_illegal (csr_illegal),
        .tohost      (tohost),
        .tohost_wr   (tohost_wr)
    );

    csr_counter64 #(.W(64), .INIT(64'h0000_0000_FFFF_FFFF)) u_cnt_a (
        .clk (clk), .rst_n (c_clr_n), .inc (c_inc), .lo (ca_lo), .hi (ca_hi)
    );

    csr_counter64 #(.W(64), .INIT(64'hFFFF_FFFF_FFFF_FFFF)) u_cnt_b (
        .clk (clk), .rst_n (c_clr_n), .inc (c_inc), .lo (cb_lo), .hi (cb_hi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural read of a CSR address from model state; ok=0 for unmapped
    task automatic model_read(input logic [11:0] a, output logic [31:0] v, output logic ok);
        ok = 1'b1;
        v  = 32'h0;
        if (a == 12'h51E)                    v = m_tohost;
        else if (a == 12'hC00 || a == 12'hC01) v = m_cycle[31:0];
        else if (a == 12'hC80 || a == 12'hC81) v = m_cycle[63:32];
        else if (a == 12'hC02)               v = m_instret[31:0];
        else if (a == 12'hC82)               v = m_instret[63:32];
        else                                 ok = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        logic [31:0] old_v, src_v, new_v;
        logic        ok, we, ill;
        if (!rst_n) begin
            m_cycle = 0; m_instret = 0; m_tohost = 32'h0;
            m_rd = 0; m_ill = 0; m_wr = 0;
            return;
        end
        model_read(csr_addr, old_v, ok);
        if (valid && csr_en && !stall && funct3 != 3'd0 && funct3 != 3'd4) begin
            src_v = (funct3 >= 3'd5) ? imm : rs1_data;
            if (funct3 == 3'd1 || funct3 == 3'd5)      we = 1'b1;
            else if (funct3 >= 3'd5)                   we = (imm % 32) != 0;
            else                                       we = (rs1_idx != 0);
            if (funct3 == 3'd1 || funct3 == 3'd5)      new_v = src_v;
            else if (funct3 == 3'd2 || funct3 == 3'd6) new_v = old_v | src_v;
            else                                       new_v = old_v & ~src_v;
            ill   = !ok || (csr_addr >= 12'hC00 && we);
            m_rd  = old_v;
            m_ill = ill;
            m_wr  = 1'b0;
            if (!ill && we && csr_addr == 12'h51E) begin
                m_tohost = new_v;
                m_wr     = 1'b1;
            end
        end else begin
            m_wr = 1'b0;
            if (!stall) begin
                m_rd  = 0;
                m_ill = 0;
            end
        end
        m_cycle = m_cycle + 1;
        if (retire) m_instret = m_instret + 1;
    endtask

    // One clock edge: update model, then sample all outputs 1 ns after the edge
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_data",     rd_data,              m_rd);
        chk("csr_illegal", {31'b0, csr_illegal}, {31'b0, m_ill});
        chk("tohost",      tohost,               m_tohost);
        chk("tohost_wr",   {31'b0, tohost_wr},   {31'b0, m_wr});
    endtask

    task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                      input logic [31:0] rs1, input logic [31:0] im);
        valid = 1'b1; csr_en = 1'b1; funct3 = f3; csr_addr = a;
        rs1_idx = idx; rs1_data = rs1; imm = im;
    endtask

    task automatic idle();
        valid = 1'b0; csr_en = 1'b0; funct3 = 3'd0; csr_addr = 12'h0;
        rs1_idx = 5'd0; rs1_data = 32'h0; imm = 32'h0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] rs1;
        logic [31:0] im;
        logic [31:0] e_rd;
        logic        e_ill;
        logic [31:0] e_th;
        logic        e_wr;
    } vec_t;

    vec_t vt[12];

    logic [11:0] addr_pool[10];

    initial begin
        vt[0]  = '{3'b001, 12'h51E, 5'd1, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        vt[1]  = '{3'b010, 12'h51E, 5'd5, 32'h000000F0, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEFF, 1'b1};
        vt[2]  = '{3'b001, 12'h51E, 5'd2, 32'h0000000F, 32'h0,        32'hDEADBEFF, 1'b0, 32'h0000000F, 1'b1};
        vt[3]  = '{3'b111, 12'h51E, 5'd0, 32'h0,        32'h0,        32'h0000000F, 1'b0, 32'h0000000F, 1'b0};
        vt[4]  = '{3'b111, 12'h51E, 5'd0, 32'h0,        32'h3,        32'h0000000F, 1'b0, 32'h0000000C, 1'b1};
        vt[5]  = '{3'b110, 12'h51E, 5'd0, 32'h0,        32'h10,       32'h0000000C, 1'b0, 32'h0000001C, 1'b1};
        vt[6]  = '{3'b011, 12'h51E, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0000001C, 1'b0, 32'h0000001C, 1'b0};
        vt[7]  = '{3'b101, 12'h51E, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0000001C, 1'b0, 32'h00000000, 1'b1};
        vt[8]  = '{3'b001, 12'h123, 5'd1, 32'h5,        32'h0,        32'h0,        1'b1, 32'h00000000, 1'b0};
        vt[9]  = '{3'b010, 12'h7C0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b1, 32'h00000000, 1'b0};
        vt[10] = '{3'b101, 12'h51E, 5'd0, 32'h0,        32'h1F,       32'h0,        1'b0, 32'h0000001F, 1'b1};
        vt[11] = '{3'b110, 12'h51E, 5'd3, 32'h0,        32'hFFFFFFE0, 32'h0000001F, 1'b0, 32'h0000001F, 1'b0};

        addr_pool = '{12'h51E, 12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
                      12'hC03, 12'h51F, 12'h300};

        c_clr_n = 1'b0; c_inc = 1'b0;
        m_cycle = 0; m_instret = 0; m_tohost = 0; m_rd = 0; m_ill = 0; m_wr = 0;
        rst_n = 1'b0; stall = 1'b0; retire = 1'b0;
        idle();

        // Reset for 3 cycles, then 10 idle edges, then read the cycle counter
        for (int i = 0; i < 3; i++) step();
        chk("reset_tohost",  tohost,  32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_illegal", {31'b0, csr_illegal}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        op(3'b010, 12'hC00, 5'd0, 32'h0, 32'h0); step();
        chk("cycle_after_10", rd_data, 32'd10);
        op(3'b010, 12'hC01, 5'd0, 32'h0, 32'h0); step();
        chk("time_alias", rd_data, 32'd11);
        op(3'b010, 12'hC80, 5'd0, 32'h0, 32'h0); step();
        chk("cycleh_zero", rd_data, 32'd0);

        // Retire 4 instructions, then an illegal write to instret must not disturb it
        idle(); retire = 1'b1;
        for (int i = 0; i < 4; i++) step();
        retire = 1'b0;
        op(3'b001, 12'hC02, 5'd1, 32'h100, 32'h0); step();
        chk("ro_write_illegal", {31'b0, csr_illegal}, 32'h1);
        chk("ro_write_rd", rd_data, 32'd4);
        op(3'b010, 12'hC02, 5'd0, 32'h0, 32'h0); step();
        chk("ro_read_legal", {31'b0, csr_illegal}, 32'h0);
        chk("instret_unchanged", rd_data, 32'd4);

        // Directed vector table (tohost is 0 here)
        for (int i = 0; i < 12; i++) begin
            op(vt[i].f3, vt[i].addr, vt[i].idx, vt[i].rs1, vt[i].im);
            step();
            chk($sformatf("vec%0d_rd", i),     rd_data,              vt[i].e_rd);
            chk($sformatf("vec%0d_ill", i),    {31'b0, csr_illegal}, {31'b0, vt[i].e_ill});
            chk($sformatf("vec%0d_tohost", i), tohost,               vt[i].e_th);
            chk($sformatf("vec%0d_wr", i),     {31'b0, tohost_wr},   {31'b0, vt[i].e_wr});
        end

        // Stall blocks the write and holds rd_data; reset drops an issuing write
        op(3'b001, 12'h51E, 5'd1, 32'hAAAA0000, 32'h0); step();
        op(3'b001, 12'h51E, 5'd1, 32'h00001234, 32'h0); step();
        chk("pre_stall_rd", rd_data, 32'hAAAA0000);
        stall = 1'b1;
        op(3'b001, 12'h51E, 5'd1, 32'h00005555, 32'h0); step(); step();
        chk("stall_rd_hold", rd_data, 32'hAAAA0000);
        chk("stall_no_write", tohost, 32'h00001234);
        chk("stall_no_pulse", {31'b0, tohost_wr}, 32'h0);
        stall = 1'b0; rst_n = 1'b0; step();
        chk("reset_drops_write", tohost, 32'h0);
        chk("reset_rd_clear", rd_data, 32'h0);
        rst_n = 1'b1; idle(); step();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            valid    = ($urandom_range(0, 3) != 0);
            csr_en   = ($urandom_range(0, 4) != 0);
            funct3   = 3'($urandom_range(0, 7));
            csr_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 9)];
            rs1_idx  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            rs1_data = $urandom;
            imm      = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31));
            stall    = ($urandom_range(0, 3) == 0);
            retire   = $urandom_range(0, 1) == 1;
            rst_n    = ($urandom_range(0, 59) != 0);
            step();
        end
        rst_n = 1'b1; stall = 1'b0; retire = 1'b0; idle();

        // Counter wrap: low-half carry and full 64-bit wrap
        c_clr_n = 1'b0; c_inc = 1'b0;
        @(posedge clk); #1;
        chk("cnt_a_init_lo", ca_lo, 32'hFFFFFFFF);
        chk("cnt_a_init_hi", ca_hi, 32'h0);
        c_clr_n = 1'b1; c_inc = 1'b1;
        @(posedge clk); #1;
        chk("cnt_a_carry_lo", ca_lo, 32'h0);
        chk("cnt_a_carry_hi", ca_hi, 32'h1);
        chk("cnt_b_wrap_lo",  cb_lo, 32'h0);
        chk("cnt_b_wrap_hi",  cb_hi, 32'h0);
        c_inc = 1'b0;
        @(posedge clk); #1;
        chk("cnt_a_hold_lo", ca_lo, 32'h0);
        chk("cnt_b_hold_lo", cb_lo, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
